scan_chain_loader: RTL and testbench

Serial scan master that drives the scan port of the memory bank. It fills the chain from a byte stream on a valid/ready input and returns the displaced chain contents as a byte stream on a valid/ready output, so memory and I/O state can be loaded and dumped in one pass. It sits between the debug/host byte link (upstream) and the memory bank's `scan_enable`/`scan_in`/`scan_out` pins (downstream). Shifting stalls, with the chain holding its contents, whenever either side is not ready.

---
 rtl/scan_pkg.sv | 18 +
 rtl/scan_byte_deser.sv | 56 +++++
 rtl/scan_chain_loader.sv | 129 ++++++++++++
 tb/tb_scan_chain_loader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Shared types and helpers for the scan chain loader: controller states,
// stream byte width and the bytes-per-chain calculation.
package scan_pkg;

    localparam int SCAN_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN,
        DONE
    } scan_state_t;

    function automatic int nbytes(input int len);
        return (len + SCAN_BYTE_W - 1) / SCAN_BYTE_W;
    endfunction

endpackage

// File: rtl/scan_byte_deser.sv
// Output byte assembler: gathers scan_out bits LSB first and presents complete
// bytes on a valid/ready port. A flush closes a short final byte, leaving its upper bits zero.
module scan_byte_deser
    import scan_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   bit_valid,
    input  logic                   bit_data,
    input  logic [2:0]             bit_pos,
    input  logic                   flush,
    output logic                   can_take,
    output logic [SCAN_BYTE_W-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    logic [SCAN_BYTE_W-1:0] acc;
    logic [SCAN_BYTE_W-1:0] acc_next;
    logic                   complete;

    always_comb begin
        acc_next          = acc;
        acc_next[bit_pos] = bit_data;
    end

    assign complete = bit_valid && ((bit_pos == 3'd7) || flush);
    assign can_take = !out_valid || out_ready;

    // The accumulator is separate from out_data so a new byte can start
    // in the same cycle the previous one is handed off.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (clear) begin
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (complete) begin
                out_data  <= acc_next;
                out_valid <= 1'b1;
                acc       <= '0;
            end else if (bit_valid) begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: rtl/scan_chain_loader.sv
// Scan master: shifts a byte stream into the attached chain LSB first while
// returning the displaced chain bits as a byte stream. Stalls when either side is not ready.
module scan_chain_loader
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 2056,
    parameter int BYTE_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              scan_enable,
    output logic              scan_in,
    input  logic              scan_out
);

    localparam int NBYTES     = nbytes(CHAIN_LEN);
    localparam int CNT_W      = $clog2(CHAIN_LEN + 1);
    localparam int BYTE_CNT_W = $clog2(NBYTES + 1);

    scan_state_t            state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [2:0]             bit_pos;
    logic [BYTE_W-1:0]      in_byte;
    logic                   in_full;
    logic [BYTE_CNT_W-1:0]  bytes_taken;

    logic last_bit;
    logic shift_en;
    logic in_last;
    logic in_accept;
    logic deser_can_take;
    logic deser_clear;

    assign last_bit    = (bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign shift_en    = (state == SHIFT) && in_full && deser_can_take;
    assign in_last     = shift_en && ((bit_pos == 3'd7) || last_bit);
    assign in_ready    = busy && (!in_full || in_last) &&
                         (bytes_taken != BYTE_CNT_W'(NBYTES));
    assign in_accept   = in_valid && in_ready;
    assign deser_clear = (state == IDLE) && start;

    assign scan_enable = shift_en;
    assign scan_in     = shift_en && in_byte[bit_pos];

    // Later assignments in the IDLE branch override the refill/shift
    // bookkeeping so a fresh start always begins from clean counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_cnt     <= '0;
            bit_pos     <= '0;
            in_byte     <= '0;
            in_full     <= 1'b0;
            bytes_taken <= '0;
        end else begin
            done <= 1'b0;

            if (in_accept) begin
                in_byte     <= in_data;
                in_full     <= 1'b1;
                bytes_taken <= bytes_taken + BYTE_CNT_W'(1);
            end else if (in_last) begin
                in_full <= 1'b0;
            end

            if (shift_en) begin
                bit_pos <= bit_pos + 3'd1;
                if (bit_cnt != CNT_W'(CHAIN_LEN)) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= SHIFT;
                        busy        <= 1'b1;
                        bit_cnt     <= '0;
                        bit_pos     <= '0;
                        in_full     <= 1'b0;
                        bytes_taken <= '0;
                    end
                end
                SHIFT: begin
                    if (shift_en && last_bit) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    scan_byte_deser u_deser (
        .clk       (clk),
        .rst       (rst),
        .clear     (deser_clear),
        .bit_valid (shift_en),
        .bit_data  (scan_out),
        .bit_pos   (bit_pos),
        .flush     (last_bit),
        .can_take  (deser_can_take),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench: a 16-bit and a 12-bit loader, each attached to a behavioural
// scan chain, driven by table vectors plus hand-written stall/reset sequences.
module tb_scan_chain_loader;

    typedef struct {
        logic [15:0] preload;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [7:0]  exp0;
        logic [7:0]  exp1;
        logic [15:0] exp_chain;
    } vec_t;

    logic clk;
    logic rst;

    logic       a_start, a_busy, a_done, a_in_valid, a_in_ready;
    logic       a_out_valid, a_out_ready, a_se, a_si, a_so;
    logic [7:0] a_in_data, a_out_data;
    logic       b_start, b_busy, b_done, b_in_valid, b_in_ready;
    logic       b_out_valid, b_out_ready, b_se, b_si, b_so;
    logic [7:0] b_in_data, b_out_data;

    logic [15:0] chain_a;
    logic [11:0] chain_b;
    logic        a_load, b_load;
    logic [15:0] a_load_val;
    logic [11:0] b_load_val;

    logic [7:0] a_in_q[$];
    logic [7:0] a_out_q[$];
    logic [7:0] b_in_q[$];
    logic [7:0] b_out_q[$];
    logic       a_feed, b_feed;
    logic       a_last_se;

    int cyc, checks, failures;
    int a_done_cnt, a_done_cyc, a_se_cnt, a_start_cyc, a_done_lat;
    int b_done_cnt, b_done_cyc, b_se_cnt, b_start_cyc, b_done_lat;

    vec_t vecs[4];

    scan_chain_loader #(.CHAIN_LEN(16), .BYTE_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .scan_enable(a_se), .scan_in(a_si), .scan_out(a_so)
    );

    scan_chain_loader #(.CHAIN_LEN(12), .BYTE_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .scan_enable(b_se), .scan_in(b_si), .scan_out(b_so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_load) chain_a <= a_load_val;
        else if (a_se) chain_a <= {a_si, chain_a[15:1]};
        if (b_load) chain_b <= b_load_val;
        else if (b_se) chain_b <= {b_si, chain_b[11:1]};
    end
    assign a_so = chain_a[0];
    assign b_so = chain_b[0];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_inputs();
        a_in_valid = a_feed && (a_in_q.size() > 0);
        a_in_data  = (a_in_q.size() > 0) ? a_in_q[0] : 8'h00;
        b_in_valid = b_feed && (b_in_q.size() > 0);
        b_in_data  = (b_in_q.size() > 0) ? b_in_q[0] : 8'h00;
    endtask

    // One clock: observe handshakes mid-cycle, then advance and re-drive.
    task automatic step();
        logic a_acc, b_acc;
        @(negedge clk);
        a_acc = a_in_valid && a_in_ready;
        b_acc = b_in_valid && b_in_ready;
        if (a_out_valid && a_out_ready) a_out_q.push_back(a_out_data);
        if (b_out_valid && b_out_ready) b_out_q.push_back(b_out_data);
        if (a_done) begin a_done_cnt++; a_done_cyc = cyc; end
        if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
        if (a_se) a_se_cnt++;
        if (b_se) b_se_cnt++;
        a_last_se = a_se;
        @(posedge clk);
        #1;
        cyc++;
        if (a_acc && a_in_q.size() > 0) void'(a_in_q.pop_front());
        if (b_acc && b_in_q.size() > 0) void'(b_in_q.pop_front());
        drive_inputs();
    endtask

    task automatic apply_stimulus_a(input logic [15:0] pre, input logic [7:0] b0, input logic [7:0] b1);
        a_load_val = pre;
        a_load = 1'b1;
        step();
        a_load = 1'b0;
        a_in_q.delete();
        a_in_q.push_back(b0);
        a_in_q.push_back(b1);
        drive_inputs();
    endtask

    task automatic begin_a();
        a_out_q.delete();
        a_done_cnt = 0;
        a_se_cnt = 0;
        a_start = 1'b1;
        a_start_cyc = cyc;
        step();
        a_start = 1'b0;
    endtask

    task automatic finish_a(input int budget);
        for (int i = 0; i < budget && a_done_cnt == 0; i++) step();
        if (a_done_cnt == 0) check_output("a_done_timeout", 0, 1);
        a_done_lat = a_done_cyc - a_start_cyc;
    endtask

    task automatic check_bytes_a(input string tag, input logic [7:0] e0, input logic [7:0] e1);
        check_output({tag, "_out_count"}, a_out_q.size(), 2);
        check_output({tag, "_out0"}, (a_out_q.size() > 0) ? a_out_q[0] : 8'hxx, e0);
        check_output({tag, "_out1"}, (a_out_q.size() > 1) ? a_out_q[1] : 8'hxx, e1);
    endtask

    initial begin
        checks = 0; failures = 0; cyc = 0;
        rst = 1'b0;
        a_start = 1'b0; a_out_ready = 1'b1; a_feed = 1'b1; a_load = 1'b0; a_load_val = '0;
        b_start = 1'b0; b_out_ready = 1'b1; b_feed = 1'b1; b_load = 1'b0; b_load_val = '0;
        a_in_valid = 1'b0; a_in_data = '0; b_in_valid = 1'b0; b_in_data = '0;
        a_last_se = 1'b0;
        a_done_cnt = 0; a_done_cyc = 0; a_se_cnt = 0; a_start_cyc = 0; a_done_lat = 0;
        b_done_cnt = 0; b_done_cyc = 0; b_se_cnt = 0; b_start_cyc = 0; b_done_lat = 0;

        vecs[0] = '{16'hBEEF, 8'h12, 8'h34, 8'hEF, 8'hBE, 16'h3412};
        vecs[1] = '{16'h0000, 8'hFF, 8'h00, 8'h00, 8'h00, 16'h00FF};
        vecs[2] = '{16'hA55A, 8'h0F, 8'hF0, 8'h5A, 8'hA5, 16'hF00F};
        vecs[3] = '{16'hFFFF, 8'h80, 8'h01, 8'hFF, 8'hFF, 16'h0180};

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_a_outputs",
                     {a_busy, a_done, a_in_ready, a_out_valid, a_out_data, a_se, a_si}, 0);
        check_output("reset_b_outputs",
                     {b_busy, b_done, b_in_ready, b_out_valid, b_out_data, b_se, b_si}, 0);
        #2 rst = 1'b1;

        // Full-rate passes on the 16-bit chain.
        for (int v = 0; v < 4; v++) begin
            apply_stimulus_a(vecs[v].preload, vecs[v].b0, vecs[v].b1);
            begin_a();
            finish_a(40);
            check_bytes_a($sformatf("vec%0d", v), vecs[v].exp0, vecs[v].exp1);
            check_output($sformatf("vec%0d_chain", v), chain_a, vecs[v].exp_chain);
            check_output($sformatf("vec%0d_done_lat", v), a_done_lat, 19);
            check_output($sformatf("vec%0d_shifts", v), a_se_cnt, 16);
            check_output($sformatf("vec%0d_busy_after", v), a_busy, 0);
        end

        // Partial final byte on the 12-bit chain.
        b_load_val = 12'hABC;
        b_load = 1'b1;
        step();
        b_load = 1'b0;
        b_in_q.delete();
        b_in_q.push_back(8'hFF);
        b_in_q.push_back(8'hFF);
        drive_inputs();
        b_out_q.delete();
        b_done_cnt = 0;
        b_se_cnt = 0;
        b_start = 1'b1;
        b_start_cyc = cyc;
        step();
        b_start = 1'b0;
        for (int i = 0; i < 40 && b_done_cnt == 0; i++) step();
        if (b_done_cnt == 0) check_output("b_done_timeout", 0, 1);
        b_done_lat = b_done_cyc - b_start_cyc;
        check_output("part_out_count", b_out_q.size(), 2);
        check_output("part_out0", (b_out_q.size() > 0) ? b_out_q[0] : 8'hxx, 8'hBC);
        check_output("part_out1", (b_out_q.size() > 1) ? b_out_q[1] : 8'hxx, 8'h0A);
        check_output("part_chain", chain_b, 12'hFFF);
        check_output("part_done_lat", b_done_lat, 15);
        check_output("part_shifts", b_se_cnt, 12);

        // Input stall: second byte withheld after the first is exhausted.
        apply_stimulus_a(16'h9966, 8'h5A, 8'h00);
        void'(a_in_q.pop_back());
        drive_inputs();
        begin_a();
        for (int i = 0; i < 40 && a_se_cnt < 8; i++) step();
        check_output("stall_mid_chain", chain_a, 16'h5A99);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("stall_se", a_last_se, 0);
            check_output("stall_chain", chain_a, 16'h5A99);
        end
        a_in_q.push_back(8'hC3);
        drive_inputs();
        step();
        check_output("stall_accept_cycle_se", a_last_se, 0);
        step();
        check_output("stall_resume_se", a_last_se, 1);
        finish_a(40);
        check_bytes_a("stall", 8'h66, 8'h99);
        check_output("stall_chain_end", chain_a, 16'hC35A);
        check_output("stall_shifts", a_se_cnt, 16);

        // Output backpressure once the first byte is presented.
        apply_stimulus_a(16'h1234, 8'hAA, 8'h55);
        begin_a();
        for (int i = 0; i < 40 && a_se_cnt < 8; i++) step();
        a_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("bp_valid", a_out_valid, 1);
            check_output("bp_data", a_out_data, 8'h34);
            check_output("bp_se", a_se, 0);
        end
        check_output("bp_shift_count", a_se_cnt, 8);
        a_out_ready = 1'b1;
        finish_a(40);
        check_bytes_a("bp", 8'h34, 8'h12);
        check_output("bp_chain_end", chain_a, 16'h55AA);
        check_output("bp_done_cnt", a_done_cnt, 1);

        // Reset while bit 7 is shifting.
        apply_stimulus_a(16'h0000, 8'hFF, 8'hFF);
        begin_a();
        for (int i = 0; i < 40 && a_se_cnt < 7; i++) step();
        check_output("rst_pre_se", a_se, 1);
        #2 rst = 1'b0;
        #1;
        check_output("rst_outputs_zero",
                     {a_busy, a_done, a_in_ready, a_out_valid, a_out_data, a_se, a_si}, 0);
        check_output("rst_chain_kept", chain_a, 16'hFE00);
        #2 rst = 1'b1;
        apply_stimulus_a(16'h0F0F, 8'h21, 8'h43);
        begin_a();
        finish_a(40);
        check_bytes_a("post_rst", 8'h0F, 8'h0F);
        check_output("post_rst_chain", chain_a, 16'h4321);
        check_output("post_rst_done_lat", a_done_lat, 19);

        // Idle input is ignored; a second start while busy is ignored.
        apply_stimulus_a(16'hCAFE, 8'h77, 8'h88);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("idle_in_ready", a_in_ready, 0);
        end
        check_output("idle_queue_kept", a_in_q.size(), 2);
        begin_a();
        check_output("start_busy", a_busy, 1);
        check_output("start_in_ready", a_in_ready, 1);
        repeat (3) step();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        finish_a(40);
        repeat (25) step();
        check_output("busy_one_done", a_done_cnt, 1);
        check_output("busy_idle_after", a_busy, 0);
        check_bytes_a("busy", 8'hFE, 8'hCA);
        check_output("busy_chain_end", chain_a, 16'h8877);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
